// File: rtl/rx_core_pkg.sv
// Shared rx-core definitions: sync header codes, block-sync state encoding
// and the default lock/unlock thresholds used by the gearbox and top level.
package rx_core_pkg;

   // Legal 64b/66b sync headers
   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // Block-sync state encoding
   typedef enum logic [1:0] {
      ST_HUNT      = 2'd0,
      ST_LOCKED    = 2'd1,
      ST_SLIP_WAIT = 2'd2
   } sync_state_e;

   // Default thresholds
   localparam int unsigned DEF_LOCK_COUNT = 64;
   localparam int unsigned DEF_ERR_LIMIT  = 16;
   localparam int unsigned DEF_WINDOW     = 64;
   localparam int unsigned DEF_SLIP_WAIT  = 32;

endpackage : rx_core_pkg

// File: rtl/rx_block_sync.sv
// 64b/66b block-lock stage between the 32->66 gearbox and the descrambler.
// Hunts for block alignment by checking sync headers and commanding gearbox
// bitslips; once locked, forwards aligned blocks and monitors header errors.
//
// Ports:
//   clk            rx user clock
//   rst            synchronous active-high reset
//   data_in        66-bit block from gearbox, header in [65:64]
//   data_in_valid  data_in holds a new block this cycle
//   data_out       registered copy of data_in (latency 1)
//   data_out_valid block on data_out was sampled while locked
//   slip           single-cycle bitslip request to the gearbox
//   locked         block lock achieved
//   slip_count     saturating count of slips since reset
module rx_block_sync
   import rx_core_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int unsigned ERR_LIMIT  = DEF_ERR_LIMIT,
   parameter int unsigned WINDOW     = DEF_WINDOW,
   parameter int unsigned SLIP_WAIT  = DEF_SLIP_WAIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [65:0] data_in,
   input  logic        data_in_valid,
   output logic [65:0] data_out,
   output logic        data_out_valid,
   output logic        slip,
   output logic        locked,
   output logic [15:0] slip_count
);

   localparam int unsigned MAX_AB  = (LOCK_COUNT > ERR_LIMIT) ? LOCK_COUNT : ERR_LIMIT;
   localparam int unsigned MAX_CD  = (WINDOW > SLIP_WAIT) ? WINDOW : SLIP_WAIT;
   localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   sync_state_e      state_q;
   logic [CNT_W-1:0] good_cnt_q;
   logic [CNT_W-1:0] win_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [65:0]      data_out_q;
   logic             data_out_valid_q;
   logic             slip_q;
   logic             locked_q;
   logic [15:0]      slip_count_q;

   logic             hdr_ok_c;
   logic [CNT_W-1:0] good_nxt_c;
   logic [CNT_W-1:0] win_nxt_c;
   logic [CNT_W-1:0] err_nxt_c;
   logic [CNT_W-1:0] wait_nxt_c;
   logic [15:0]      slip_count_inc_c;

   // Header check and counter increments
   always_comb begin
      hdr_ok_c         = (data_in[65:64] == SYNC_DATA) || (data_in[65:64] == SYNC_CTRL);
      good_nxt_c       = good_cnt_q + CNT_W'(1);
      win_nxt_c        = win_cnt_q + CNT_W'(1);
      err_nxt_c        = err_cnt_q + CNT_W'(!hdr_ok_c);
      wait_nxt_c       = wait_cnt_q + CNT_W'(1);
      slip_count_inc_c = (slip_count_q == 16'hFFFF) ? slip_count_q : slip_count_q + 16'd1;
   end

   // Lock FSM with registered outputs; only data_in_valid cycles advance it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_HUNT;
         good_cnt_q       <= '0;
         win_cnt_q        <= '0;
         err_cnt_q        <= '0;
         wait_cnt_q       <= '0;
         data_out_q       <= '0;
         data_out_valid_q <= 1'b0;
         slip_q           <= 1'b0;
         locked_q         <= 1'b0;
         slip_count_q     <= '0;
      end else begin
         slip_q           <= 1'b0;
         data_out_valid_q <= data_in_valid && (state_q == ST_LOCKED);
         if (data_in_valid) begin
            data_out_q <= data_in;
            case (state_q)
               ST_HUNT: begin
                  if (hdr_ok_c) begin
                     if (good_nxt_c == CNT_W'(LOCK_COUNT)) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        good_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        err_cnt_q  <= '0;
                     end else begin
                        good_cnt_q <= good_nxt_c;
                     end
                  end else begin
                     state_q      <= ST_SLIP_WAIT;
                     slip_q       <= 1'b1;
                     slip_count_q <= slip_count_inc_c;
                     good_cnt_q   <= '0;
                     wait_cnt_q   <= '0;
                  end
               end
               ST_LOCKED: begin
                  // Unlock takes priority over a coincident window close
                  if (err_nxt_c == CNT_W'(ERR_LIMIT)) begin
                     state_q      <= ST_SLIP_WAIT;
                     locked_q     <= 1'b0;
                     slip_q       <= 1'b1;
                     slip_count_q <= slip_count_inc_c;
                     good_cnt_q   <= '0;
                     win_cnt_q    <= '0;
                     err_cnt_q    <= '0;
                     wait_cnt_q   <= '0;
                  end else if (win_nxt_c == CNT_W'(WINDOW)) begin
                     win_cnt_q <= '0;
                     err_cnt_q <= '0;
                  end else begin
                     win_cnt_q <= win_nxt_c;
                     err_cnt_q <= err_nxt_c;
                  end
               end
               ST_SLIP_WAIT: begin
                  // Gearbox is realigning; headers are ignored here
                  if (wait_nxt_c == CNT_W'(SLIP_WAIT)) begin
                     state_q    <= ST_HUNT;
                     good_cnt_q <= '0;
                     wait_cnt_q <= '0;
                  end else begin
                     wait_cnt_q <= wait_nxt_c;
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = data_out_valid_q;
   assign slip           = slip_q;
   assign locked         = locked_q;
   assign slip_count     = slip_count_q;

endmodule : rx_block_sync

// File: tb/tb_rx_block_sync.sv
// Directed bench for rx_block_sync: forwarded blocks are queued by the
// stimulus and popped by an independent output monitor.
module tb_rx_block_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [65:0] data_in;
   logic        data_in_valid;
   logic [65:0] data_out;
   logic        data_out_valid;
   logic        slip;
   logic        locked;
   logic [15:0] slip_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          seq      = 0;
   int          slip_pulses = 0;
   logic        prev_slip = 1'b0;
   logic [65:0] exp_q[$];

   rx_block_sync dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .slip           (slip),
      .locked         (locked),
      .slip_count     (slip_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One block per call; returns 1 time unit after the capturing edge
   task automatic send(input logic [1:0] hdr, input bit fwd);
      logic [63:0] pl;
      @(negedge clk);
      seq++;
      pl = {16'hC0DE, 16'(seq), 32'(seq) * 32'h9E37_79B9};
      data_in       = {hdr, pl};
      data_in_valid = 1'b1;
      if (fwd) exp_q.push_back({hdr, pl});
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      data_in       = {2'b00, ~pl};
   endtask

   task automatic send_n(input logic [1:0] hdr, input int n, input bit fwd);
      for (int i = 0; i < n; i++) send(hdr, fwd);
   endtask

   // Valid block followed by one idle cycle carrying an invalid header
   task automatic send_gap(input logic [1:0] hdr, input bit fwd);
      send(hdr, fwd);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard compare and slip pulse width
   always @(posedge clk) begin
      #1;
      if (data_out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL data_out_unexpected: got valid block %h expected none", data_out);
         end else begin
            check("data_out", data_out, exp_q.pop_front());
         end
      end
      if (slip === 1'b1) begin
         check("slip_width", 66'(prev_slip), 66'(0));
         if (prev_slip !== 1'b1) slip_pulses++;
      end
      prev_slip = slip;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach end of test");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      data_in       = '0;
      data_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", 66'(locked), 66'(0));
      check("rst_slip", 66'(slip), 66'(0));
      check("rst_slip_count", 66'(slip_count), 66'(0));
      check("rst_data_out_valid", 66'(data_out_valid), 66'(0));
      check("rst_data_out", data_out, 66'(0));
      @(negedge clk);
      rst = 1'b0;

      // Initial lock on 64 good headers; the 64th is not forwarded
      send_n(2'b01, 63, 1'b0);
      check("t1_not_locked_63", 66'(locked), 66'(0));
      send(2'b10, 1'b0);
      check("t1_locked_64", 66'(locked), 66'(1));
      check("t1_slip_count", 66'(slip_count), 66'(0));
      send(2'b01, 1'b1);

      // 15 errors in a window hold lock, the 16th unlocks (still forwarded)
      send_n(2'b11, 15, 1'b1);
      check("t3_locked_15err", 66'(locked), 66'(1));
      check("t3_slip_count_15err", 66'(slip_count), 66'(0));
      send(2'b11, 1'b1);
      check("t3_unlock", 66'(locked), 66'(0));
      check("t3_slip", 66'(slip), 66'(1));
      check("t3_slip_count", 66'(slip_count), 66'(1));
      @(posedge clk);
      #1;
      check("t3_slip_drop", 66'(slip), 66'(0));

      // Realign wait, then a bad header at hunt block 10
      send_n(2'b01, 32, 1'b0);
      send_n(2'b01, 9, 1'b0);
      send(2'b00, 1'b0);
      check("t2_slip", 66'(slip), 66'(1));
      check("t2_slip_count", 66'(slip_count), 66'(2));
      check("t2_not_locked", 66'(locked), 66'(0));
      // Bad headers during the wait are not evaluated
      send_n(2'b11, 32, 1'b0);
      check("t2_wait_ignores_hdr", 66'(slip_count), 66'(2));
      send_n(2'b01, 63, 1'b0);
      check("t2_not_locked_63", 66'(locked), 66'(0));
      send(2'b01, 1'b0);
      check("t2_relocked", 66'(locked), 66'(1));

      // Error counter clears at each window boundary
      send_n(2'b01, 54, 1'b1);
      send_n(2'b00, 10, 1'b1);
      check("t4_locked_w1", 66'(locked), 66'(1));
      send_n(2'b11, 10, 1'b1);
      send_n(2'b10, 54, 1'b1);
      check("t4_locked_w2", 66'(locked), 66'(1));
      // 16th error lands on the window's last block: unlock wins
      send_n(2'b01, 48, 1'b1);
      send_n(2'b11, 15, 1'b1);
      check("t4_locked_w3_15err", 66'(locked), 66'(1));
      send(2'b11, 1'b1);
      check("t4_unlock_at_window_end", 66'(locked), 66'(0));
      check("t4_slip_count", 66'(slip_count), 66'(3));

      // Gapped valid: idle cycles carry invalid headers and change nothing
      for (int i = 0; i < 32; i++) send_gap(2'b01, 1'b0);
      for (int i = 0; i < 63; i++) send_gap(2'b01, 1'b0);
      check("t5_not_locked_63", 66'(locked), 66'(0));
      check("t5_slip_count", 66'(slip_count), 66'(3));
      send_gap(2'b10, 1'b0);
      check("t5_locked", 66'(locked), 66'(1));
      for (int i = 0; i < 3; i++) send_gap(2'b01, 1'b1);

      // Reset while locked
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_locked", 66'(locked), 66'(0));
      check("t6_data_out_valid", 66'(data_out_valid), 66'(0));
      check("t6_slip_count", 66'(slip_count), 66'(0));
      check("t6_data_out", data_out, 66'(0));
      @(negedge clk);
      rst = 1'b0;
      send_n(2'b01, 63, 1'b0);
      check("t6_not_locked_63", 66'(locked), 66'(0));
      send(2'b01, 1'b0);
      check("t6_relocked", 66'(locked), 66'(1));
      send(2'b10, 1'b1);
      @(posedge clk);
      #2;

      check("queue_empty", 66'(exp_q.size()), 66'(0));
      check("slip_pulses", 66'(slip_pulses), 66'(3));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rx_block_sync

// File: doc/rx_block_sync.md
Name: rx_block_sync

Overview:
64b/66b block-lock stage in the kintex7 rx-core.
- Sits between the 32->66 gearbox and the descrambler.
- Checks the 2-bit sync header of each 66-bit block arriving from the gearbox.
- Finds block alignment by commanding bitslips on the gearbox.
- Once locked, forwards aligned blocks with a valid strobe that drives the descrambler enable.

Parameters:
- LOCK_COUNT, 64: consecutive valid headers required to declare lock.
- ERR_LIMIT, 16: invalid headers within one window that cause loss of lock.
- WINDOW, 64: blocks per error-monitoring window while locked.
- SLIP_WAIT, 32: valid blocks ignored after each slip, while the gearbox realigns.

Ports:
- clk  in  1: rx user clock.
- rst  in  1: reset.
- data_in  in  66: block from gearbox; sync header in data_in[65:64], payload in data_in[63:0].
- data_in_valid  in  1: data_in holds a new block this cycle.
- data_out  out  66: registered copy of data_in, header kept in [65:64]; feeds the descrambler data_in.
- data_out_valid  out  1: block on data_out is aligned and locked; feeds the descrambler enable.
- slip  out  1: single-cycle bitslip request to the gearbox.
- locked  out  1: block lock achieved.
- slip_count  out  16: saturating count of slips issued since reset.

Behaviour:
- Reset: rst synchronous, active-high; clock clk. All outputs reset to 0, state HUNT, all counters 0.
- Header check: header valid iff data_in[65:64] is 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid.
- Gating: only cycles with data_in_valid=1 are evaluated. When data_in_valid=0, all counters and the state hold.
- States: HUNT, LOCKED, SLIP_WAIT.

HUNT:
- Valid header: good_cnt++.
- good_cnt reaching LOCK_COUNT (the 64th consecutive valid header): next state LOCKED. locked=1 on the following cycle.
- Invalid header: slip=1 for the next cycle, slip_count++ (saturates at 16'hFFFF), good_cnt cleared, go to SLIP_WAIT.

LOCKED:
- Each valid block: win_cnt++.
- Invalid header: err_cnt++.
- err_cnt reaching ERR_LIMIT: locked=0 next cycle, slip pulse, slip_count++, counters cleared, go to SLIP_WAIT.
- win_cnt reaching WINDOW with no unlock: win_cnt and err_cnt cleared; that block's error still counts in the window it closes.
- Simultaneous window end and ERR_LIMIT-th error: unlock wins.

SLIP_WAIT:
- Counts data_in_valid cycles.
- After SLIP_WAIT of them, go to HUNT with good_cnt=0.
- Headers are not evaluated in this state.

Outputs:
- slip: exactly one cycle per slip event. Never asserted twice within SLIP_WAIT valid blocks.
- data_out: registers data_in on every data_in_valid cycle; latency 1.
- data_out_valid: data_in_valid registered AND (state==LOCKED at sampling time), so the block that triggers unlock is still forwarded.
- The 64th hunt block (the one that achieves lock) is not forwarded.

Reset mid-operation: rst in any state returns to the reset values on the next edge. A slip in flight is dropped.

Counter widths: good_cnt, win_cnt and err_cnt are clog2(max parameter)+1 bits. No wrap is possible because each counter is cleared at its threshold.

Decomposition:
- rx_core_pkg holds:
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10;
  - the state encoding (HUNT, LOCKED, SLIP_WAIT, 2 bits);
  - the default LOCK_COUNT, ERR_LIMIT, WINDOW and SLIP_WAIT values shared with the gearbox and top level.
- No sub-module; the header check is a single expression inside the block.

Test Plan:
1. After rst, 64 blocks with header 2'b01 and data_in_valid=1 -> locked=1 on the cycle after block 64; data_out_valid first 1 for block 65, one cycle later, with data_out == block 65.
2. In HUNT, block 10 has header 2'b00 -> slip high exactly 1 cycle, slip_count=1, no lock. After 32 ignored blocks plus 64 valid ones, locked=1.
3. Locked, then 15 invalid headers (2'b11) within one 64-block window -> locked stays 1. A 16th in the same window -> locked=0 next cycle, one slip pulse, slip_count increments.
4. Locked, 10 errors in window 1 and 10 errors in window 2 -> locked stays 1 throughout (err_cnt cleared at the window boundary).
5. In HUNT, data_in_valid toggling 1/0 each cycle with valid headers -> lock after 64 valid blocks (~128 cycles). Cycles with data_in_valid=0 change nothing.
6. rst asserted for 1 cycle while locked -> next cycle locked=0, data_out_valid=0, slip_count=0, data_out=0. Relock requires 64 fresh valid blocks.
